// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the 7-segment scan capture block.
//   - FSM state enum for the per-sample settle tracker
//   - 16-entry hex glyph table (active-high, bit order gfedcba)
//   - segment bit indices and default digit count
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_e;

    localparam int DEF_NUM_DIGITS = 8;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational exact-match decode of an active-high
// 7-segment glyph to a hex nibble.
//   glyph_i  [6:0] active-high glyph, bit order gfedcba
//   val_o    [3:0] decoded nibble, 0 when the glyph is not a hex glyph
//   hex_ok_o       1 when the glyph is one of the 16 hex glyphs
module seg7_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] glyph_i,
    output logic [3:0] val_o,
    output logic       hex_ok_o
);

    always_comb begin
        val_o    = 4'd0;
        hex_ok_o = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (glyph_i == HEX_GLYPH[k]) begin
                val_o    = 4'(k);
                hex_ok_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed seg/an display bus, rejects
// glitches and anode-transition ghosting, and rebuilds the digit frame as
// raw glyphs plus decoded hex nibbles.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   seg [6:0]           segment lines (polarity per SEG_ACTIVE_LOW)
//   an  [NUM_DIGITS-1:0] active-low anode enables
//   clr                 synchronous clear of frame, seen mask and scan_err
//   digit_code          captured active-high glyphs, 7 bits per digit
//   digit_val           decoded nibbles, 4 bits per digit
//   digit_hex_ok        per-digit hex-glyph flag
//   digit_valid         per-digit captured-since-clear flag
//   frame_done          one-cycle pulse when every digit has been captured
//   scan_err            sticky ghosting / scan-order error
// Optional: define SEG_SCAN_ORDER_CHECK_EN to flag out-of-order captures.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    clr,
    output logic [7*NUM_DIGITS-1:0] digit_code,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_hex_ok,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    scan_err
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    scan_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  prev_seg_q;
    logic [NUM_DIGITS-1:0] prev_an_q;

    logic [NUM_DIGITS-1:0][6:0] code_q;
    logic [NUM_DIGITS-1:0][3:0] val_q;
    logic [NUM_DIGITS-1:0] hexok_q, valid_q, seen_q;
    logic frame_q, err_q;

    logic [6:0]       seg_n;
    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]       nsel;
    logic [IDX_W-1:0] idx;
    logic             same, blank, multi, capture;
    logic [3:0]       dec_val;
    logic             dec_ok;

    // The current sample is the value being registered this edge; it is
    // compared against the previously registered one.
    assign seg_n = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    assign sel   = ~an;
    assign same  = (seg_n == prev_seg_q) && (an == prev_an_q);

    always_comb begin
        nsel = 4'd0;
        idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                nsel = nsel + 4'd1;
                idx  = IDX_W'(i);
            end
        end
    end

    assign blank = (nsel == 4'd0);
    assign multi = (nsel > 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_seg_q <= '0;
            prev_an_q  <= '0;
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
        end else begin
            prev_seg_q <= seg_n;
            prev_an_q  <= an;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (multi || blank) begin
            state_d = ST_BLANK;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end
                ST_SETTLE: begin
                    if (!same) begin
                        cnt_d = 8'd1;
                    end else if (cnt_q == 8'(STABLE_CYCLES - 1)) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_HELD: begin
                    if (!same) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    seg7_glyph_decode u_dec (
        .glyph_i  (seg_n),
        .val_o    (dec_val),
        .hex_ok_o (dec_ok)
    );

`ifdef SEG_SCAN_ORDER_CHECK_EN
    logic [IDX_W-1:0] last_idx_q;
    logic             have_last_q;
    logic [IDX_W-1:0] exp_idx;
    logic             order_bad;

    assign exp_idx   = (last_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : last_idx_q + 1'b1;
    assign order_bad = capture && have_last_q && (idx != exp_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_idx_q  <= '0;
            have_last_q <= 1'b0;
        end else if (clr) begin
            last_idx_q  <= '0;
            have_last_q <= 1'b0;
        end else if (capture) begin
            last_idx_q  <= idx;
            have_last_q <= 1'b1;
        end
    end
`else
    logic order_bad;
    assign order_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= '0;
            val_q   <= '0;
            hexok_q <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (clr) begin
                code_q  <= '0;
                val_q   <= '0;
                hexok_q <= '0;
                valid_q <= '0;
                seen_q  <= '0;
                err_q   <= 1'b0;
            end else begin
                if (multi || order_bad) begin
                    err_q <= 1'b1;
                end
                if (capture) begin
                    code_q[idx]  <= seg_n;
                    val_q[idx]   <= dec_val;
                    hexok_q[idx] <= dec_ok;
                    valid_q[idx] <= 1'b1;
                    // Completing the set pulses frame_done and restarts tracking.
                    if ((seen_q | sel) == {NUM_DIGITS{1'b1}}) begin
                        seen_q  <= '0;
                        frame_q <= 1'b1;
                    end else begin
                        seen_q <= seen_q | sel;
                    end
                end
            end
        end
    end

    assign digit_code   = code_q;
    assign digit_val    = val_q;
    assign digit_hex_ok = hexok_q;
    assign digit_valid  = valid_q;
    assign frame_done   = frame_q;
    assign scan_err     = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [7:0]  an  = 8'hFF;
    logic        clr = 1'b0;
    logic [55:0] digit_code;
    logic [31:0] digit_val;
    logic [7:0]  digit_hex_ok;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        scan_err;

    int n_vec = 0;
    int n_err = 0;
    int pulses;
    int width;
    int run;
    logic [55:0] exp_code;

    seg_scan_capture #(
        .NUM_DIGITS     (8),
        .STABLE_CYCLES  (4),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg          (seg),
        .an           (an),
        .clr          (clr),
        .digit_code   (digit_code),
        .digit_val    (digit_val),
        .digit_hex_ok (digit_hex_ok),
        .digit_valid  (digit_valid),
        .frame_done   (frame_done),
        .scan_err     (scan_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving the bench 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".code"},  64'(digit_code),   64'h0);
        check({tag, ".val"},   64'(digit_val),    64'h0);
        check({tag, ".hexok"}, 64'(digit_hex_ok), 64'h0);
        check({tag, ".valid"}, 64'(digit_valid),  64'h0);
        check({tag, ".frame"}, 64'(frame_done),   64'h0);
        check({tag, ".err"},   64'(scan_err),     64'h0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        step(2);
        rst = 1'b0;
        step(2);

        // 1: digit 0 shows "1" (active-low 7'h79); captured on the 4th edge
        an = 8'hFE; seg = 7'h79;
        step(3);
        check("t1_early_valid", 64'(digit_valid[0]), 64'h0);
        step(1);
        check("t1_val",   64'(digit_val[3:0]),  64'h1);
        check("t1_hexok", 64'(digit_hex_ok[0]), 64'h1);
        check("t1_valid", 64'(digit_valid[0]),  64'h1);
        check("t1_code",  64'(digit_code[6:0]), 64'h06);

        // 2: short dwell of "5" on digit 1
        an = 8'hFD; seg = 7'h12;
        step(3);
        an = 8'hFF; seg = 7'h7F;
        step(2);
        check("t2_valid1", 64'(digit_valid[1]), 64'h0);

        // 3: full frame "0000000F", digits 0..7 in order
        clr = 1'b1; step(1); clr = 1'b0;
        check("t3_clr_valid", 64'(digit_valid), 64'h0);
        pulses = 0; width = 0; run = 0;
        for (int d = 0; d < 8; d++) begin
            an  = ~(8'h01 << d);
            seg = (d == 7) ? 7'h0E : 7'h40;
            for (int c = 0; c < 6; c++) begin
                step(1);
                if (frame_done) begin
                    if (run == 0) pulses++;
                    run++;
                    if (run > width) width = run;
                end else begin
                    run = 0;
                end
            end
        end
        an = 8'hFF; seg = 7'h7F;
        for (int c = 0; c < 3; c++) begin
            step(1);
            if (frame_done) begin
                if (run == 0) pulses++;
                run++;
                if (run > width) width = run;
            end else begin
                run = 0;
            end
        end
        check("t3_pulses", 64'(pulses), 64'd1);
        check("t3_width",  64'(width),  64'd1);
        check("t3_val",    64'(digit_val),    64'hF000_0000);
        check("t3_valid",  64'(digit_valid),  64'hFF);
        check("t3_hexok",  64'(digit_hex_ok), 64'hFF);
        exp_code = {7'h71, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        check("t3_code",   64'(digit_code), 64'(exp_code));
        check("t3_err",    64'(scan_err),   64'h0);

        // 4: ghosting across two anodes for one cycle
        an = 8'hFC; seg = 7'h40;
        step(1);
        check("t4_err", 64'(scan_err), 64'h1);
        an = 8'hFF; seg = 7'h7F;
        step(3);
        check("t4_err_sticky", 64'(scan_err),  64'h1);
        check("t4_val_kept",   64'(digit_val), 64'hF000_0000);
        check("t4_code_kept",  64'(digit_code), 64'(exp_code));
        clr = 1'b1; step(1); clr = 1'b0;
        check("t4_err_clr", 64'(scan_err), 64'h0);

        // 5: non-hex "-" (active-high 7'h40) on digit 2
        an = 8'hFB; seg = 7'h3F;
        step(5);
        check("t5_code",  64'(digit_code[20:14]), 64'h40);
        check("t5_hexok", 64'(digit_hex_ok[2]),   64'h0);
        check("t5_val",   64'(digit_val[11:8]),   64'h0);
        check("t5_valid", 64'(digit_valid[2]),    64'h1);

        // seg change under a fixed anode: last stable glyph ("3") wins
        an = 8'hF7; seg = 7'h79;
        step(2);
        seg = 7'h30;
        step(4);
        check("t5b_val",  64'(digit_val[15:12]),  64'h3);
        check("t5b_code", 64'(digit_code[27:21]), 64'h4F);

        // 6: asynchronous reset in the middle of a settle
        an = 8'hFE; seg = 7'h79;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        step(1);
        rst = 1'b0;
        an = 8'hFF; seg = 7'h7F;
        step(1);

        // scan digit 0 then digit 2: order error only with the order check built
        an = 8'hFE; seg = 7'h40;
        step(5);
        an = 8'hFB; seg = 7'h40;
        step(5);
        an = 8'hFF; seg = 7'h7F;
        step(1);
        check("t6_valid2", 64'(digit_valid[2]), 64'h1);
        check("t6_val2",   64'(digit_val[11:8]), 64'h0);
`ifdef SEG_SCAN_ORDER_CHECK_EN
        check("t6_order_err", 64'(scan_err), 64'h1);
`else
        check("t6_order_err", 64'(scan_err), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
